// File: rtl/eda_regional_max_scan_if.sv
// Result stream of the regional-maximum scanner: one centre pixel per
// valid/ready handshake.
interface eda_regional_max_scan_if #(
    parameter int ROW_W       = 3,
    parameter int COL_W       = 3,
    parameter int PIXEL_WIDTH = 8
);
    logic                   out_valid;
    logic                   out_ready;
    logic [ROW_W-1:0]       out_row;
    logic [COL_W-1:0]       out_col;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic                   out_is_max;

    modport master (
        output out_valid, out_row, out_col, out_pixel, out_is_max,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row, out_col, out_pixel, out_is_max,
        output out_ready
    );
endinterface

// File: rtl/eda_regional_max_scan.sv
// Holds an M x N image and streams, in raster order, each pixel with a flag
// telling whether it is a local maximum over its 4- or 8-connected window.
module eda_regional_max_scan #(
    parameter int M           = 6,
    parameter int N           = 6,
    parameter int PIXEL_WIDTH = 8,
    parameter int ROW_W       = $clog2(M),
    parameter int COL_W       = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   write_en,
    input  logic [ROW_W+COL_W-1:0] wr_addr,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   conn8,
    input  logic                   strict,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    eda_regional_max_scan_if.master res
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                 state;
    logic [PIXEL_WIDTH-1:0] img [M][N];
    logic [ROW_W-1:0]       cur_row;
    logic [COL_W-1:0]       cur_col;
    logic                   conn8_q;
    logic                   strict_q;

    logic [ROW_W-1:0]       wr_row;
    logic [COL_W-1:0]       wr_col;
    logic                   wr_ok;
    logic                   load;
    logic                   last_col;
    logic                   last_row;
    logic [PIXEL_WIDTH-1:0] centre;
    logic                   is_max_c;

    assign wr_row   = wr_addr[ROW_W+COL_W-1:COL_W];
    assign wr_col   = wr_addr[COL_W-1:0];
    assign wr_ok    = write_en && (int'(wr_row) < M) && (int'(wr_col) < N);
    assign load     = !res.out_valid || res.out_ready;
    assign last_col = (cur_col == COL_W'(N - 1));
    assign last_row = (cur_row == ROW_W'(M - 1));

    // Window offsets k = 0..8 map to (k/3-1, k%3-1); odd k are the orthogonal
    // neighbours, even k other than 4 are diagonals.
    always_comb begin
        int r;
        int c;
        r        = 0;
        c        = 0;
        centre   = img[cur_row][cur_col];
        is_max_c = 1'b1;
        for (int unsigned k = 0; k < 9; k++) begin
            r = int'(cur_row) + int'(k / 3) - 1;
            c = int'(cur_col) + int'(k % 3) - 1;
            if (k != 4 && (conn8_q || k[0]) && r >= 0 && r < M && c >= 0 && c < N) begin
                if (strict_q ? (img[r[ROW_W-1:0]][c[COL_W-1:0]] >= centre)
                             : (img[r[ROW_W-1:0]][c[COL_W-1:0]] >  centre))
                    is_max_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            img            <= '{default: '0};
            cur_row        <= '0;
            cur_col        <= '0;
            conn8_q        <= 1'b0;
            strict_q       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            res.out_valid  <= 1'b0;
            res.out_row    <= '0;
            res.out_col    <= '0;
            res.out_pixel  <= '0;
            res.out_is_max <= 1'b0;
        end else if (clear) begin
            state         <= IDLE;
            img           <= '{default: '0};
            busy          <= 1'b0;
            done          <= 1'b0;
            res.out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays up through the done cycle, then drops
                    if (done)
                        busy <= 1'b0;
                    if (wr_ok)
                        img[wr_row][wr_col] <= pixel_in;
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        cur_row  <= '0;
                        cur_col  <= '0;
                        conn8_q  <= conn8;
                        strict_q <= strict;
                    end
                end
                SCAN: begin
                    if (load) begin
                        res.out_valid  <= 1'b1;
                        res.out_row    <= cur_row;
                        res.out_col    <= cur_col;
                        res.out_pixel  <= centre;
                        res.out_is_max <= is_max_c;
                        if (last_col) begin
                            cur_col <= '0;
                            if (last_row)
                                state <= DRAIN;
                            else
                                cur_row <= cur_row + 1'b1;
                        end else begin
                            cur_col <= cur_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (res.out_ready) begin
                        res.out_valid <= 1'b0;
                        state         <= IDLE;
                        done          <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eda_regional_max_scan.sv
// Directed bench for eda_regional_max_scan on a 6x6 image; inputs are driven
// and outputs sampled on the falling clock edge.
module tb_eda_regional_max_scan;

    localparam int M  = 6;
    localparam int N  = 6;
    localparam int PW = 8;
    localparam int RW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          write_en;
    logic [RW+CW-1:0] wr_addr;
    logic [PW-1:0] pixel_in;
    logic          conn8;
    logic          strict;
    logic          start;
    logic          busy;
    logic          done;

    eda_regional_max_scan_if #(.ROW_W(RW), .COL_W(CW), .PIXEL_WIDTH(PW)) res ();

    eda_regional_max_scan #(
        .M(M), .N(N), .PIXEL_WIDTH(PW), .ROW_W(RW), .COL_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .write_en(write_en),
        .wr_addr(wr_addr), .pixel_in(pixel_in), .conn8(conn8), .strict(strict),
        .start(start), .busy(busy), .done(done), .res(res)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit pat [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1};

    // Results captured by run_scan
    int n_res, first_valid, last_hs, done_cyc, done_cnt, stall_changes;
    logic busy0, busy_at_done, busy_after;
    int r_row [64];
    int r_col [64];
    int r_pix [64];
    int r_max [64];

    task automatic write_px(input int r, input int c, input logic [PW-1:0] v);
        write_en = 1'b1;
        wr_addr  = {3'(r), 3'(c)};
        pixel_in = v;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic fill(input logic [PW-1:0] v);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                write_px(r, c, v);
    endtask

    // Runs one scan; conn8/strict are inverted after start to show they are latched.
    task automatic run_scan(input logic c8, input logic st, input bit bp, input bit do_wr);
        logic          held_valid;
        logic [RW-1:0] h_row;
        logic [CW-1:0] h_col;
        logic [PW-1:0] h_pix;
        logic          h_max;
        bit            rdy;
        held_valid = 1'b0;
        h_row = '0; h_col = '0; h_pix = '0; h_max = 1'b0;
        n_res = 0; first_valid = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
        stall_changes = 0; busy_at_done = 1'b0; busy_after = 1'b1;
        for (int i = 0; i < 64; i++) begin
            r_row[i] = -1; r_col[i] = -1; r_pix[i] = -1; r_max[i] = -1;
        end
        conn8 = c8; strict = st; res.out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        conn8  = ~c8;
        strict = ~st;
        busy0  = busy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc)     busy_at_done = busy;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after   = busy;
            if (res.out_valid && first_valid < 0) first_valid = cyc;
            if (held_valid && res.out_valid &&
                (res.out_row !== h_row || res.out_col !== h_col ||
                 res.out_pixel !== h_pix || res.out_is_max !== h_max))
                stall_changes++;
            if (do_wr && cyc == 3) begin
                write_en = 1'b1; wr_addr = {3'd5, 3'd5}; pixel_in = 8'hAA;
            end else begin
                write_en = 1'b0;
            end
            rdy = bp ? pat[cyc % 12] : 1'b1;
            res.out_ready = rdy;
            if (res.out_valid && rdy) begin
                if (n_res < 64) begin
                    r_row[n_res] = int'(res.out_row);
                    r_col[n_res] = int'(res.out_col);
                    r_pix[n_res] = int'(res.out_pixel);
                    r_max[n_res] = int'(res.out_is_max);
                end
                n_res++;
                last_hs    = cyc;
                held_valid = 1'b0;
            end else if (res.out_valid) begin
                held_valid = 1'b1;
                h_row = res.out_row; h_col = res.out_col;
                h_pix = res.out_pixel; h_max = res.out_is_max;
            end else begin
                held_valid = 1'b0;
            end
            @(negedge clk);
        end
        write_en = 1'b0;
        res.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)           begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (res.out_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", res.out_valid); end
        total++; if (res.out_row !== 3'd0)    begin bad++; $display("FAIL reset_row got=%0d exp=0", res.out_row); end
        total++; if (res.out_col !== 3'd0)    begin bad++; $display("FAIL reset_col got=%0d exp=0", res.out_col); end
        total++; if (res.out_pixel !== 8'h00) begin bad++; $display("FAIL reset_pixel got=%h exp=00", res.out_pixel); end
        total++; if (res.out_is_max !== 1'b0) begin bad++; $display("FAIL reset_is_max got=%b exp=0", res.out_is_max); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat_ge();
        fill(8'h10);
        run_scan(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (busy0 !== 1'b1)   begin bad++; $display("FAIL flat_busy_start got=%b exp=1", busy0); end
        total++; if (first_valid !== 1) begin bad++; $display("FAIL flat_first_latency got=%0d exp=1", first_valid); end
        total++; if (n_res !== 36)     begin bad++; $display("FAIL flat_count got=%0d exp=36", n_res); end
        for (int i = 0; i < 36; i++) begin
            total++; if (r_row[i] !== i / 6 || r_col[i] !== i % 6)
                begin bad++; $display("FAIL flat_pos[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, r_row[i], r_col[i], i / 6, i % 6); end
            total++; if (r_pix[i] !== 32'h10)
                begin bad++; $display("FAIL flat_pixel[%0d] got=%0h exp=10", i, r_pix[i]); end
            total++; if (r_max[i] !== 1)
                begin bad++; $display("FAIL flat_ge_max[%0d] got=%0d exp=1", i, r_max[i]); end
        end
        total++; if (last_hs !== 36)   begin bad++; $display("FAIL flat_last_hs got=%0d exp=36", last_hs); end
        total++; if (done_cyc !== 37)  begin bad++; $display("FAIL flat_done_cycle got=%0d exp=37", done_cyc); end
        total++; if (done_cnt !== 1)   begin bad++; $display("FAIL flat_done_count got=%0d exp=1", done_cnt); end
        total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL flat_busy_at_done got=%b exp=1", busy_at_done); end
        total++; if (busy_after !== 1'b0)   begin bad++; $display("FAIL flat_busy_after got=%b exp=0", busy_after); end
    endtask

    task automatic test_flat_strict();
        run_scan(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (n_res !== 36) begin bad++; $display("FAIL strict_count got=%0d exp=36", n_res); end
        for (int i = 0; i < 36; i++) begin
            total++; if (r_max[i] !== 0)
                begin bad++; $display("FAIL strict_max[%0d] got=%0d exp=0", i, r_max[i]); end
        end
    endtask

    task automatic test_peaks();
        fill(8'h00);
        write_px(2, 2, 8'h80);
        write_px(3, 3, 8'h90);
        run_scan(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (n_res !== 36) begin bad++; $display("FAIL peaks8_count got=%0d exp=36", n_res); end
        for (int i = 0; i < 36; i++) begin
            total++; if (r_max[i] !== ((i == 21) ? 1 : 0))
                begin bad++; $display("FAIL peaks8_max[%0d] got=%0d exp=%0d", i, r_max[i], (i == 21) ? 1 : 0); end
        end
        run_scan(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) begin
            total++; if (r_max[i] !== ((i == 14 || i == 21) ? 1 : 0))
                begin bad++; $display("FAIL peaks4_max[%0d] got=%0d exp=%0d", i, r_max[i], (i == 14 || i == 21) ? 1 : 0); end
        end
    endtask

    task automatic test_backpressure();
        run_scan(1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (n_res !== 36)        begin bad++; $display("FAIL bp_count got=%0d exp=36", n_res); end
        total++; if (stall_changes !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", stall_changes); end
        total++; if (done_cnt !== 1)      begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
        total++; if (done_cyc !== last_hs + 1 || last_hs < 0)
            begin bad++; $display("FAIL bp_done_cycle got=%0d exp=%0d", done_cyc, last_hs + 1); end
        for (int i = 0; i < 36; i++) begin
            total++; if (r_row[i] !== i / 6 || r_col[i] !== i % 6)
                begin bad++; $display("FAIL bp_pos[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, r_row[i], r_col[i], i / 6, i % 6); end
            total++; if (r_max[i] !== ((i == 14 || i == 21) ? 1 : 0))
                begin bad++; $display("FAIL bp_max[%0d] got=%0d exp=%0d", i, r_max[i], (i == 14 || i == 21) ? 1 : 0); end
        end
    endtask

    task automatic test_corner();
        fill(8'h01);
        write_px(0, 0, 8'hFF);
        run_scan(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (r_pix[0] !== 32'hFF) begin bad++; $display("FAIL corner_pixel got=%0h exp=ff", r_pix[0]); end
        for (int i = 0; i < 36; i++) begin
            total++; if (r_max[i] !== ((i == 0) ? 1 : 0))
                begin bad++; $display("FAIL corner_max[%0d] got=%0d exp=%0d", i, r_max[i], (i == 0) ? 1 : 0); end
        end
    endtask

    task automatic test_write_during_scan();
        int wrong;
        fill(8'h22);
        run_scan(1'b1, 1'b0, 1'b0, 1'b1);
        wrong = 0;
        for (int i = 0; i < 36; i++)
            if (r_pix[i] !== 32'h22) wrong++;
        total++; if (n_res !== 36) begin bad++; $display("FAIL scanwr_count got=%0d exp=36", n_res); end
        total++; if (wrong !== 0)  begin bad++; $display("FAIL scanwr_pixels wrong=%0d exp=0", wrong); end
        total++; if (r_pix[35] !== 32'h22) begin bad++; $display("FAIL scanwr_target got=%0h exp=22", r_pix[35]); end
    endtask

    task automatic test_clear();
        int  hs;
        int  seen;
        int  nonzero;
        bit  hit;
        fill(8'h33);
        conn8 = 1'b1; strict = 1'b0; res.out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; hit = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (res.out_valid) hs++;
            if (hs == 10) begin hit = 1'b1; clear = 1'b1; end
            @(negedge clk);
        end
        clear = 1'b0;
        total++; if (!hit)                   begin bad++; $display("FAIL clear_reach got=%0d exp=10", hs); end
        total++; if (res.out_valid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b exp=0", res.out_valid); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL clear_busy got=%b exp=0", busy); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done !== 1'b0 || res.out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL clear_no_done got=%0d exp=0", seen); end
        clear = 1'b1; start = 1'b1; write_en = 1'b1; wr_addr = {3'd1, 3'd1}; pixel_in = 8'h55;
        @(negedge clk);
        clear = 1'b0; start = 1'b0; write_en = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_prio_busy got=%b exp=0", busy); end
        run_scan(1'b1, 1'b0, 1'b0, 1'b0);
        nonzero = 0;
        for (int i = 0; i < 36; i++)
            if (r_pix[i] !== 0) nonzero++;
        total++; if (n_res !== 36)  begin bad++; $display("FAIL clear_rescan_count got=%0d exp=36", n_res); end
        total++; if (nonzero !== 0) begin bad++; $display("FAIL clear_image nonzero=%0d exp=0", nonzero); end
        total++; if (r_pix[7] !== 0) begin bad++; $display("FAIL clear_prio_write got=%0h exp=0", r_pix[7]); end
    endtask

    task automatic test_reset_mid();
        int hs;
        int seen;
        int nonzero;
        bit hit;
        fill(8'h44);
        conn8 = 1'b1; strict = 1'b0; res.out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; hit = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (res.out_valid) hs++;
            if (hs == 20) hit = 1'b1;
            else @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        total++; if (!hit)                   begin bad++; $display("FAIL rst_reach got=%0d exp=20", hs); end
        total++; if (res.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", res.out_valid); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || res.out_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", seen); end
        run_scan(1'b1, 1'b0, 1'b0, 1'b0);
        nonzero = 0;
        for (int i = 0; i < 36; i++)
            if (r_pix[i] !== 0) nonzero++;
        total++; if (nonzero !== 0) begin bad++; $display("FAIL rst_image nonzero=%0d exp=0", nonzero); end
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; write_en = 1'b0; start = 1'b0;
        conn8 = 1'b0; strict = 1'b0; wr_addr = '0; pixel_in = '0;
        res.out_ready = 1'b0;
        test_reset();
        test_flat_ge();
        test_flat_strict();
        test_peaks();
        test_backpressure();
        test_corner();
        test_write_during_scan();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
